// File: rtl/countdown_timer_if.sv
// countdown_timer_if: key inputs and display/status outputs of the countdown timer
// Ports (signals):
//   key_start, key_cancel, key_min, key_tens : active-low pushbuttons (master drives)
//   remaining[18:0]                          : remaining time in centiseconds
//   hex5..hex0[6:0]                          : MM:SS.cc seven-segment digits, active-low gfedcba
//   led[9:0], alarm                          : status / alarm indication
// Modports: master (key source, display sink), slave (the timer).
interface countdown_timer_if;
    logic        key_start;
    logic        key_cancel;
    logic        key_min;
    logic        key_tens;
    logic [18:0] remaining;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
    logic [9:0]  led;
    logic        alarm;
    modport master (
        output key_start, key_cancel, key_min, key_tens,
        input  remaining, hex5, hex4, hex3, hex2, hex1, hex0, led, alarm
    );
    modport slave (
        input  key_start, key_cancel, key_min, key_tens,
        output remaining, hex5, hex4, hex3, hex2, hex1, hex0, led, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS.cc kitchen-style countdown timer with preset keys, pause and flashing alarm
// Ports:
//   refclk : 100 Hz clock, one cycle = one centisecond
//   reset  : asynchronous active-low reset
//   bus    : countdown_timer_if.slave (keys in; remaining, hex5..hex0, led, alarm out)
// Parameters: BLINK_HALF (cycles per LED flash half-period), ALARM_TIMEOUT (auto-clear delay)
// Optional feature: define COUNTDOWN_ALARM_TIMEOUT_EN to clear the alarm after ALARM_TIMEOUT idle cycles.
module countdown_timer #(
    parameter int BLINK_HALF    = 50,
    parameter int ALARM_TIMEOUT = 1000
) (
    input logic refclk,
    input logic reset,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;
    state_t state;
    // Key vectors are ordered {cancel, start, min, tens}, i.e. highest priority first.
    logic [3:0]  sync1, sync2, sync3, fall;
    logic        ev_cancel, ev_start, ev_min, ev_tens, ev_any, to_idle, timeout_hit;
    logic [5:0]  pre_min, nxt_min;
    logic [2:0]  pre_tens, nxt_tens;
    logic [18:0] preset, nxt_preset, remaining, rem_dec, mins, secs, cents;
    logic [9:0]  led;
    logic        alarm;
    logic [31:0] blink_cnt;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
    logic [31:0] timeout_cnt;
    assign timeout_hit = timeout_cnt == 32'(ALARM_TIMEOUT - 1);
`else
    assign timeout_hit = 1'b0;
`endif

    function automatic logic [6:0] sevenseg_decimal(input logic [3:0] d);
        case (d)
            4'd0:    sevenseg_decimal = 7'h40;
            4'd1:    sevenseg_decimal = 7'h79;
            4'd2:    sevenseg_decimal = 7'h24;
            4'd3:    sevenseg_decimal = 7'h30;
            4'd4:    sevenseg_decimal = 7'h19;
            4'd5:    sevenseg_decimal = 7'h12;
            4'd6:    sevenseg_decimal = 7'h02;
            4'd7:    sevenseg_decimal = 7'h78;
            4'd8:    sevenseg_decimal = 7'h00;
            4'd9:    sevenseg_decimal = 7'h10;
            default: sevenseg_decimal = 7'h7F;
        endcase
    endfunction

    function automatic logic [9:0] sec_led(input logic [18:0] v);
        sec_led = 10'd1 << ((v / 19'd100) % 19'd10);
    endfunction

    // sync3 holds the previous synchronized level, so a 1->0 step is one event.
    assign fall      = sync3 & ~sync2;
    assign ev_cancel = fall[3];
    assign ev_start  = fall[2] & ~fall[3];
    assign ev_min    = fall[1] & ~|fall[3:2];
    assign ev_tens   = fall[0] & ~|fall[3:1];
    assign ev_any    = |fall;

    assign nxt_min    = ev_min ? (pre_min == 6'd59 ? 6'd0 : pre_min + 6'd1) : pre_min;
    assign nxt_tens   = ev_tens ? (pre_tens == 3'd5 ? 3'd0 : pre_tens + 3'd1) : pre_tens;
    assign preset     = 19'(pre_min) * 19'd6000 + 19'(pre_tens) * 19'd1000;
    assign nxt_preset = 19'(nxt_min) * 19'd6000 + 19'(nxt_tens) * 19'd1000;
    assign rem_dec    = remaining - 19'd1;
    assign to_idle    = state != IDLE && (ev_cancel || (state == EXPIRED && (ev_any || timeout_hit)));

    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sync1     <= '1;
            sync2     <= '1;
            sync3     <= '1;
            pre_min   <= '0;
            pre_tens  <= '0;
            remaining <= '0;
            led       <= '0;
            alarm     <= 1'b0;
            blink_cnt <= '0;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
        end else begin
            sync1 <= {bus.key_cancel, bus.key_start, bus.key_min, bus.key_tens};
            sync2 <= sync1;
            sync3 <= sync2;
            if (to_idle) begin
                state     <= IDLE;
                remaining <= preset;
                led       <= '0;
                alarm     <= 1'b0;
                blink_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        pre_min   <= nxt_min;
                        pre_tens  <= nxt_tens;
                        remaining <= nxt_preset;
                        if (ev_start && preset != '0) begin
                            state <= RUNNING;
                            led   <= sec_led(preset);
                        end
                    end
                    RUNNING: begin
                        if (ev_start) begin
                            state <= PAUSED;
                            led   <= 10'd1;
                        end else if (remaining == 19'd1) begin
                            state     <= EXPIRED;
                            remaining <= '0;
                            alarm     <= 1'b1;
                            led       <= '1;
                            blink_cnt <= '0;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
                            timeout_cnt <= '0;
`endif
                        end else begin
                            remaining <= rem_dec;
                            led       <= sec_led(rem_dec);
                        end
                    end
                    PAUSED: begin
                        if (ev_start) begin
                            state <= RUNNING;
                            led   <= sec_led(remaining);
                        end
                    end
                    default: begin
                        blink_cnt <= blink_cnt == 32'(BLINK_HALF - 1) ? '0 : blink_cnt + 32'd1;
                        led       <= blink_cnt == 32'(BLINK_HALF - 1) ? ~led : led;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
                        timeout_cnt <= timeout_cnt + 32'd1;
`endif
                    end
                endcase
            end
        end
    end

    assign mins  = remaining / 19'd6000;
    assign secs  = (remaining / 19'd100) % 19'd60;
    assign cents = remaining % 19'd100;

    assign bus.remaining = remaining;
    assign bus.led       = led;
    assign bus.alarm     = alarm;
    assign bus.hex5      = sevenseg_decimal(4'(mins / 19'd10));
    assign bus.hex4      = sevenseg_decimal(4'(mins % 19'd10));
    assign bus.hex3      = sevenseg_decimal(4'(secs / 19'd10));
    assign bus.hex2      = sevenseg_decimal(4'(secs % 19'd10));
    assign bus.hex1      = sevenseg_decimal(4'(cents / 19'd10));
    assign bus.hex0      = sevenseg_decimal(4'(cents % 19'd10));
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard-driven self-checking bench for countdown_timer
module tb_countdown_timer;
    logic refclk = 1'b0;
    logic reset  = 1'b0;
    always #5 refclk = ~refclk;

    countdown_timer_if bus();
    countdown_timer dut (.refclk(refclk), .reset(reset), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] obs[$];
    int          passed = 0;
    int          total  = 0;
    logic [6:0]  seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // mask bits {cancel, start, min, tens}; returns 1 ns after the edge that acts on the event
    task automatic press(input logic [3:0] mask);
        repeat (3) @(negedge refclk);
        {bus.key_cancel, bus.key_start, bus.key_min, bus.key_tens} = ~mask;
        repeat (3) @(posedge refclk);
        #1;
        {bus.key_cancel, bus.key_start, bus.key_min, bus.key_tens} = 4'hF;
    endtask

    task automatic do_reset();
        @(negedge refclk);
        reset = 1'b0;
        repeat (2) @(negedge refclk);
        reset = 1'b1;
    endtask

    task automatic push(input string n, input logic [31:0] v);
        sb.push_back('{n, v});
    endtask

    task automatic test_reset();
        #1;
        push("reset_remaining", 0); push("reset_led", 0); push("reset_alarm", 0);
        obs = '{32'(bus.remaining), 32'(bus.led), 32'(bus.alarm)};
        foreach (obs[i]) begin
            exp_t e = sb.pop_front();
            total++;
            if (obs[i] !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, obs[i], e.value);
            else passed++;
        end
        repeat (2) @(negedge refclk);
        reset = 1'b1;
    endtask

    task automatic test_preset();
        press(4'b0010); press(4'b0010);
        press(4'b0001);
        push("preset_13000", 13000);
        push("hex5", 32'(seg[0])); push("hex4", 32'(seg[2])); push("hex3", 32'(seg[1]));
        push("hex2", 32'(seg[0])); push("hex1", 32'(seg[0])); push("hex0", 32'(seg[0]));
        push("idle_led", 0); push("idle_alarm", 0);
        obs = '{32'(bus.remaining), 32'(bus.hex5), 32'(bus.hex4), 32'(bus.hex3),
                32'(bus.hex2), 32'(bus.hex1), 32'(bus.hex0), 32'(bus.led), 32'(bus.alarm)};
        repeat (5) press(4'b0001);
        push("tens_wrap", 12000);
        obs.push_back(32'(bus.remaining));
        press(4'b0011);
        push("min_beats_tens", 18000);
        obs.push_back(32'(bus.remaining));
        press(4'b1000);
        push("cancel_in_idle", 18000);
        obs.push_back(32'(bus.remaining));
        foreach (obs[i]) begin
            exp_t e = sb.pop_front();
            total++;
            if (obs[i] !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, obs[i], e.value);
            else passed++;
        end
    endtask

    task automatic test_expiry();
        do_reset();
        press(4'b0001);
        press(4'b0100);
        push("start_remaining", 1000); push("start_led", 1);
        obs = '{32'(bus.remaining), 32'(bus.led)};
        @(posedge refclk); #1;
        push("run_999", 999); push("run_led_9", 10'h200);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.led));
        repeat (998) @(posedge refclk);
        #1;
        push("run_1", 1); push("run_alarm_low", 0);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.alarm));
        @(posedge refclk); #1;
        push("expired_0", 0); push("expired_alarm", 1); push("expired_led_on", 10'h3FF);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.alarm)); obs.push_back(32'(bus.led));
        repeat (49) @(posedge refclk);
        #1;
        push("blink_still_on", 10'h3FF);
        obs.push_back(32'(bus.led));
        @(posedge refclk); #1;
        push("blink_off", 0); push("blink_alarm", 1);
        obs.push_back(32'(bus.led)); obs.push_back(32'(bus.alarm));
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
        repeat (949) @(posedge refclk);
        #1;
        push("timeout_not_yet", 1);
        obs.push_back(32'(bus.alarm));
        @(posedge refclk); #1;
        push("timeout_alarm", 0); push("timeout_reload", 1000);
        obs.push_back(32'(bus.alarm)); obs.push_back(32'(bus.remaining));
`else
        repeat (4950) @(posedge refclk);
        #1;
        push("no_timeout_alarm", 1);
        obs.push_back(32'(bus.alarm));
        press(4'b0010);
        push("key_exit_alarm", 0); push("key_exit_reload", 1000);
        obs.push_back(32'(bus.alarm)); obs.push_back(32'(bus.remaining));
`endif
        foreach (obs[i]) begin
            exp_t e = sb.pop_front();
            total++;
            if (obs[i] !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, obs[i], e.value);
            else passed++;
        end
    endtask

    task automatic test_pause();
        int n = 0;
        do_reset();
        press(4'b0001);
        press(4'b0100);
        while (bus.remaining !== 19'd504 && n < 2000) begin
            @(posedge refclk); #1;
            n++;
        end
        total++;
        if (n >= 2000) $display("FAIL pause_wait: remaining %0d never reached 504", bus.remaining);
        else passed++;
        press(4'b0100);
        push("pause_frozen", 500); push("pause_led", 1);
        obs = '{32'(bus.remaining), 32'(bus.led)};
        repeat (30) @(posedge refclk);
        #1;
        push("pause_30", 500);
        obs.push_back(32'(bus.remaining));
        press(4'b0100);
        push("resume_edge", 500); push("resume_led", 10'h020);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.led));
        repeat (499) @(posedge refclk);
        #1;
        push("resume_499", 1);
        obs.push_back(32'(bus.remaining));
        @(posedge refclk); #1;
        push("resume_500", 0); push("resume_alarm", 1);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.alarm));
        press(4'b1000);
        push("cancel_expired", 1000); push("cancel_alarm", 0); push("cancel_led", 0);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.alarm)); obs.push_back(32'(bus.led));
        foreach (obs[i]) begin
            exp_t e = sb.pop_front();
            total++;
            if (obs[i] !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, obs[i], e.value);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (59) press(4'b0010);
        push("min_59", 354000);
        obs = '{32'(bus.remaining)};
        press(4'b0010);
        push("min_wrap", 0);
        obs.push_back(32'(bus.remaining));
        press(4'b0100);
        repeat (10) @(posedge refclk);
        #1;
        push("zero_start_rem", 0); push("zero_start_alarm", 0); push("zero_start_led", 0);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.alarm)); obs.push_back(32'(bus.led));
        foreach (obs[i]) begin
            exp_t e = sb.pop_front();
            total++;
            if (obs[i] !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, obs[i], e.value);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(4'b0010);
        press(4'b0100);
        repeat (100) @(posedge refclk);
        press(4'b1100);
        push("cancel_start_rem", 6000); push("cancel_start_led", 0);
        obs = '{32'(bus.remaining), 32'(bus.led)};
        repeat (20) @(posedge refclk);
        #1;
        push("cancel_start_idle", 6000);
        obs.push_back(32'(bus.remaining));
        press(4'b0100);
        repeat (100) @(posedge refclk);
        @(negedge refclk);
        reset = 1'b0;
        #1;
        push("async_rst_rem", 0); push("async_rst_led", 0); push("async_rst_alarm", 0);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.led)); obs.push_back(32'(bus.alarm));
        repeat (3) @(negedge refclk);
        reset = 1'b1;
        repeat (10) @(posedge refclk);
        #1;
        push("post_rst_rem", 0); push("post_rst_led", 0);
        obs.push_back(32'(bus.remaining)); obs.push_back(32'(bus.led));
        foreach (obs[i]) begin
            exp_t e = sb.pop_front();
            total++;
            if (obs[i] !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, obs[i], e.value);
            else passed++;
        end
    endtask

    initial begin
        {bus.key_cancel, bus.key_start, bus.key_min, bus.key_tens} = 4'hF;
        test_reset();
        test_preset();
        test_expiry();
        test_pause();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
